// File: rtl/luma_word_packer.sv
// Packs raster-ordered luma samples into BRAM words with address/write-enable.
// Optional LUMA_PACK_ROW_ALIGN_EN: every row starts a fresh, zero-padded word.
module luma_word_packer #(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 6,
    parameter int FRAME_W      = 320,
    parameter int FRAME_H      = 240,
    parameter int ADDR_W       = 17
) (
    input  logic                          clk_pixel_in,
    input  logic                          rst_n_in,
    input  logic                          pixel_valid_in,
    input  logic [PIX_W-1:0]              luma_in,
    input  logic [10:0]                   hcount_in,
    input  logic [9:0]                    vcount_in,
    output logic [PIX_W*PIX_PER_WORD-1:0] word_out,
    output logic [ADDR_W-1:0]             addr_out,
    output logic                          wea_out,
    output logic                          frame_done_out,
    output logic                          sync_err_out,
    output logic [7:0]                    err_count_out
);

    localparam int WW = PIX_W * PIX_PER_WORD;
    localparam int LW = $clog2(PIX_PER_WORD + 1);
    localparam logic [10:0]   H_MAX = 11'(FRAME_W - 1);
    localparam logic [9:0]    V_MAX = 10'(FRAME_H - 1);
    localparam logic [LW-1:0] LANES = LW'(PIX_PER_WORD);
`ifdef LUMA_PACK_ROW_ALIGN_EN
    localparam bit ROW_ALIGN = 1'b1;
`else
    localparam bit ROW_ALIGN = 1'b0;
`endif

    typedef enum logic {WAIT_SOF, RUN} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lane_q, lane_d, lane_b, lane_a;
    logic [WW-1:0]     acc_q, acc_d, acc_b, acc_a;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_b;
    logic [10:0]       exp_h_q, exp_h_d;
    logic [9:0]        exp_v_q, exp_v_d;
    logic [WW-1:0]     wr_word;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_d, done_d, err_d;
    logic              in_range, sof, match, last_col, last_px;

    assign in_range = pixel_valid_in && (hcount_in <= H_MAX)
                      && (vcount_in <= V_MAX);
    assign sof      = in_range && (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign match    = (state_q == RUN) && (hcount_in == exp_h_q)
                      && (vcount_in == exp_v_q);
    assign last_col = (hcount_in == H_MAX);
    assign last_px  = last_col && (vcount_in == V_MAX);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        exp_h_d = exp_h_q;
        exp_v_d = exp_v_q;
        lane_b  = '0;
        acc_b   = '0;
        addr_b  = '0;
        lane_a  = '0;
        acc_a   = '0;
        wr_word = '0;
        wr_addr = addr_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (in_range) begin
            if (sof || match) begin
                // SOF restarts from an empty word at address 0, even mid-frame
                lane_b  = sof ? '0 : lane_q;
                acc_b   = sof ? '0 : acc_q;
                addr_b  = sof ? '0 : addr_q;
                acc_a   = {acc_b[WW-PIX_W-1:0], luma_in};
                lane_a  = lane_b + LW'(1);
                state_d = last_px ? WAIT_SOF : RUN;
                done_d  = last_px;
                if (last_col) begin
                    exp_h_d = 11'd0;
                    exp_v_d = vcount_in + 10'd1;
                end else begin
                    exp_h_d = hcount_in + 11'd1;
                    exp_v_d = vcount_in;
                end
                if (lane_a == LANES || last_px || (ROW_ALIGN && last_col)) begin
                    wr_d    = 1'b1;
                    wr_word = acc_a << (PIX_W * (PIX_PER_WORD - int'(lane_a)));
                    wr_addr = addr_b;
                    addr_d  = addr_b + ADDR_W'(1);
                    lane_d  = '0;
                    acc_d   = '0;
                end else begin
                    lane_d  = lane_a;
                    acc_d   = acc_a;
                    addr_d  = addr_b;
                end
            end else if (state_q == RUN) begin
                err_d   = 1'b1;
                state_d = WAIT_SOF;
                lane_d  = '0;
                acc_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= WAIT_SOF;
            lane_q         <= '0;
            acc_q          <= '0;
            addr_q         <= '0;
            exp_h_q        <= '0;
            exp_v_q        <= '0;
            word_out       <= '0;
            addr_out       <= '0;
            wea_out        <= 1'b0;
            frame_done_out <= 1'b0;
            sync_err_out   <= 1'b0;
            err_count_out  <= '0;
        end else begin
            state_q        <= state_d;
            lane_q         <= lane_d;
            acc_q          <= acc_d;
            addr_q         <= addr_d;
            exp_h_q        <= exp_h_d;
            exp_v_q        <= exp_v_d;
            wea_out        <= wr_d;
            frame_done_out <= done_d;
            sync_err_out   <= err_d;
            if (wr_d) begin
                word_out <= wr_word;
                addr_out <= wr_addr;
            end
            if (err_d && err_count_out != 8'hFF)
                err_count_out <= err_count_out + 8'd1;
        end
    end

endmodule

// File: tb/tb_luma_word_packer.sv
// Bench for luma_word_packer on a 7x2 frame, 6 samples per word.
// Expectations follow LUMA_PACK_ROW_ALIGN_EN when the bench is built with it.
module tb_luma_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pixel_valid;
    logic [7:0]  luma;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [47:0] word;
    logic [16:0] addr;
    logic        wea;
    logic        done;
    logic        serr;
    logic [7:0]  ecnt;

    luma_word_packer #(
        .PIX_W(8), .PIX_PER_WORD(6), .FRAME_W(7), .FRAME_H(2), .ADDR_W(17)
    ) dut (
        .clk_pixel_in   (clk),
        .rst_n_in       (rst_n),
        .pixel_valid_in (pixel_valid),
        .luma_in        (luma),
        .hcount_in      (hcount),
        .vcount_in      (vcount),
        .word_out       (word),
        .addr_out       (addr),
        .wea_out        (wea),
        .frame_done_out (done),
        .sync_err_out   (serr),
        .err_count_out  (ecnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wea;
        logic [47:0] word;
        logic [16:0] addr;
        logic        done;
        logic        err;
    } exp_t;

    typedef struct {
        int         h;
        int         v;
        logic [7:0] luma;
        exp_t       e;
    } vec_t;

    vec_t vec [14];
    exp_t sbq [$];
    int   checks = 0;
    int   errors = 0;
    int   exp_errcnt = 0;

    function automatic exp_t idle();
        exp_t e;
        e.wea = 1'b0; e.word = '0; e.addr = '0; e.done = 1'b0; e.err = 1'b0;
        return e;
    endfunction

    function automatic exp_t wr(input logic [16:0] a, input logic [47:0] w,
                                input logic d);
        exp_t e;
        e = idle();
        e.wea = 1'b1; e.addr = a; e.word = w; e.done = d;
        return e;
    endfunction

    function automatic exp_t er();
        exp_t e;
        e = idle();
        e.err = 1'b1;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sbq.pop_front();
        if (e.err && exp_errcnt < 255) exp_errcnt++;
        cmp("wea", 64'(wea), 64'(e.wea));
        if (e.wea) begin
            cmp("word", 64'(word), 64'(e.word));
            cmp("addr", 64'(addr), 64'(e.addr));
        end
        cmp("frame_done", 64'(done), 64'(e.done));
        cmp("sync_err", 64'(serr), 64'(e.err));
        cmp("err_count", 64'(ecnt), 64'(exp_errcnt));
    endtask

    task automatic step(input logic vld, input int h, input int v,
                        input logic [7:0] l, input exp_t e);
        @(negedge clk);
        pixel_valid = vld;
        hcount      = 11'(h);
        vcount      = 10'(v);
        luma        = l;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            step(1'b1, vec[i].h, vec[i].v, vec[i].luma, vec[i].e);
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_word"}, 64'(word), 64'd0);
        cmp({tag, "_addr"}, 64'(addr), 64'd0);
        cmp({tag, "_wea"}, 64'(wea), 64'd0);
        cmp({tag, "_done"}, 64'(done), 64'd0);
        cmp({tag, "_serr"}, 64'(serr), 64'd0);
        cmp({tag, "_ecnt"}, 64'(ecnt), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 14; i++) begin
            vec[i].h    = i % 7;
            vec[i].v    = i / 7;
            vec[i].luma = 8'(i + 1);
            vec[i].e    = idle();
        end
        vec[5].e  = wr(17'd0, 48'h010203040506, 1'b0);
`ifdef LUMA_PACK_ROW_ALIGN_EN
        vec[6].e  = wr(17'd1, 48'h070000000000, 1'b0);
        vec[12].e = wr(17'd2, 48'h08090A0B0C0D, 1'b0);
        vec[13].e = wr(17'd3, 48'h0E0000000000, 1'b1);
`else
        vec[11].e = wr(17'd1, 48'h0708090A0B0C, 1'b0);
        vec[13].e = wr(17'd2, 48'h0D0E00000000, 1'b1);
`endif

        rst_n       = 1'b0;
        pixel_valid = 1'b0;
        luma        = '0;
        hcount      = '0;
        vcount      = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // clean frame
        step(1'b0, 0, 0, 8'h00, idle());
        run_vec(0, 13);
        step(1'b0, 0, 0, 8'h00, idle());

        // skipped sample (5,0), stray samples ignored until next SOF
        run_vec(0, 4);
        step(1'b1, 6, 0, 8'h77, er());
        step(1'b1, 0, 1, 8'h78, idle());
        step(1'b1, 1, 1, 8'h79, idle());
        step(1'b0, 0, 0, 8'h00, idle());
        run_vec(0, 13);

        // out-of-range mid-frame, then early SOF after 10 samples
        run_vec(0, 3);
        step(1'b1, 400, 10, 8'hAA, idle());
        run_vec(4, 9);
        run_vec(0, 13);

        // async reset with 3 lanes filled
        run_vec(0, 2);
        #2;
        rst_n = 1'b0;
        pixel_valid = 1'b0;
        #1;
        check_zero("async_rst");
        exp_errcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3, 0, 8'h33, idle());
        step(1'b1, 4, 0, 8'h44, idle());
        run_vec(0, 13);

        // error counter saturates at 255
        for (int k = 0; k < 260; k++) begin
            step(1'b1, 0, 0, 8'h01, idle());
            step(1'b1, 3, 0, 8'h02, er());
        end
        step(1'b0, 0, 0, 8'h00, idle());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/luma_word_packer.md
Name: luma_word_packer

Overview:
- Parametrised successor to the camera pipeline's greyscale packing stage: packs raster-ordered luma samples into PIX_PER_WORD-wide BRAM words and produces the matching write address and write-enable.
- Adds what the current packer lacks: start-of-frame alignment, end-of-frame flush of partial words, raster-order checking with resync, and a frame-done pulse.
- Sits between the rgb_to_ycrcb output (after valid/hcount/vcount pipelining) and the frame BRAM write port.

Parameters:
- PIX_W, 8, bits per luma sample stored
- PIX_PER_WORD, 6, samples packed per BRAM word (2..16)
- FRAME_W, 320, active pixels per row
- FRAME_H, 240, active rows per frame
- ADDR_W, 17, BRAM address width (must hold ceil(FRAME_W*FRAME_H/PIX_PER_WORD)-1)

Ports:
- clk_pixel_in  in  1  pixel clock
- rst_n_in  in  1  asynchronous, active-low reset
- pixel_valid_in  in  1  single-cycle sample strobe
- luma_in  in  PIX_W  luma sample
- hcount_in  in  11  column of sample
- vcount_in  in  10  row of sample
- word_out  out  PIX_W*PIX_PER_WORD  packed word; oldest sample in the most-significant lane
- addr_out  out  ADDR_W  word address
- wea_out  out  1  single-cycle write strobe
- frame_done_out  out  1  single-cycle pulse after the last word of a frame
- sync_err_out  out  1  single-cycle pulse on an out-of-order sample
- err_count_out  out  8  saturating count of sync errors; cleared only by reset

Behaviour:
- Clock and reset: one clock, clk_pixel_in. Reset is asynchronous and active-low (rst_n_in).
- Reset values: word_out=0, addr_out=0, wea_out=0, frame_done_out=0, sync_err_out=0, err_count_out=0. Internal lane counter, word address, and expected h/v counters are 0; state is WAIT_SOF.
- Reset mid-frame discards any partial word. Nothing is written.
- Out-of-range samples (hcount_in>=FRAME_W or vcount_in>=FRAME_H) are ignored in every state. They cause no error and no counter change.
- A valid in-range sample with hcount_in=0 and vcount_in=0 is start-of-frame (SOF).
- WAIT_SOF state:
  - Non-SOF samples are ignored.
  - On SOF: load the sample into lane 0, set lane=1, word address=0, expected position=(1,0), and go to RUN.
- RUN state:
  - A sample matching the expected (h,v) is shifted into the next lane. Expected h increments; at FRAME_W-1 it wraps to 0 and v increments.
  - When the lane count reaches PIX_PER_WORD: on the next cycle, word_out holds the word, addr_out the current word address, and wea_out=1. Then lane=0 and address increments.
  - Latency from the completing sample's valid to wea_out is exactly 1 cycle. Samples may arrive back-to-back every cycle.
- Last pixel (position FRAME_W-1, FRAME_H-1):
  - If the lane is partial, the word is written with unused low lanes zero-padded, with the same 1-cycle latency.
  - frame_done_out pulses in the same cycle as that final wea_out.
  - State goes to WAIT_SOF.
- SOF arriving in RUN (early new frame): the partial word is discarded with no write. The packer restarts as in WAIT_SOF. No error is flagged and frame_done_out is not pulsed.
- Any other in-range sample not matching the expected position:
  - sync_err_out pulses 1 cycle later.
  - err_count_out increments, saturating at 255.
  - The partial word is discarded and state goes to WAIT_SOF.
- No address multiply or divide: the address is an incrementing counter. The arithmetic is unsigned. addr_out holds its last value between writes.

Optional Feature:
- Macro: LUMA_PACK_ROW_ALIGN_EN.
- Defined:
  - Every row starts a fresh word.
  - When the sample at h=FRAME_W-1 leaves a partial lane, that word is zero-padded and written.
  - Word address is v*ceil(FRAME_W/PIX_PER_WORD)+word_in_row, kept as an incrementing counter.
- Undefined: packing is continuous across rows. Only the frame-final partial word is padded.

Test Plan:
- Test 1 (defaults): one clean 320x240 frame, valid every cycle.
  - Expect 12800 writes, addresses 0..12799, no partial word.
  - frame_done_out coincides with the write to address 12799.
  - word 0 = {p0,p1,p2,p3,p4,p5} with p0 in bits [47:40].
- Test 2: FRAME_W=7, FRAME_H=2, PIX_PER_WORD=6, samples 0x01..0x0E.
  - Expect 3 writes: addr0=0x010203040506, addr1=0x0708090A0B0C, addr2=0x0D0E00000000.
  - frame_done_out fires on the addr2 write.
- Test 3: same frame shape with LUMA_PACK_ROW_ALIGN_EN defined.
  - Expect 4 writes: addr0=0x010203040506, addr1=0x070000000000, addr2=0x08090A0B0C0D, addr3=0x0E0000000000.
- Test 4: defaults, skip sample (5,0).
  - sync_err_out pulses 1 cycle after sample (6,0); err_count_out=1.
  - No write until the next SOF; the next frame writes from address 0.
- Test 5: SOF injected after 10 samples of a frame.
  - One write (addr 0) from the first frame; no error; the new frame starts at addr 0.
  - Out-of-range sample (400,10) is ignored.
- Test 6: assert rst_n_in asynchronously with 3 lanes filled.
  - All outputs 0 immediately, with no clock edge needed.
  - Post-reset non-SOF samples are ignored until SOF.
